sudoku_grid_loader: RTL

Serial-to-parallel front end for the sudoku checker datapath. Accepts one 4-bit cell digit per handshake beat in row-major order and assembles a full 81-cell hex grid. It presents that grid as a stable 324-bit bus to the hex-to-one-hot expansion stage and holds it until it is acknowledged. It also flags out-of-range digits and framing errors.

---
 rtl/sudoku_pkg.sv | 17 +
 rtl/sudoku_digit_check.sv | 18 +
 rtl/sudoku_grid_loader.sv | 88 ++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared widths and loader state encoding for the sudoku checker datapath.
// Consumed by the loader, hex-to-one-hot expansion and checker stages.
package sudoku_pkg;

    localparam int N          = 9;
    localparam int CELLS      = N * N;
    localparam int HEX_W      = 4;
    localparam int GRID_HEX_W = CELLS * HEX_W;
    localparam int GRID_BIN_W = CELLS * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/sudoku_digit_check.sv
// Sanitizes one cell digit: 0-9 pass through, A-F become 0 and raise illegal.
// Combinational, zero latency; no flow control.
module sudoku_digit_check
    import sudoku_pkg::*;
#(
    parameter int W = HEX_W
) (
    input  logic [W-1:0] digit,
    output logic [W-1:0] clean,
    output logic         illegal
);

    always_comb begin
        illegal = (digit > W'(9));
        clean   = illegal ? '0 : digit;
    end

endmodule

// File: rtl/sudoku_grid_loader.sv
// Assembles 81 serial cell digits into a held 324-bit grid; grid_valid one cycle after beat 81.
// Backpressure: in_ready drops while a full grid is held and rises one cycle after grid_ack.
module sudoku_grid_loader #(
    parameter int N     = 9,
    parameter int HEX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [HEX_W-1:0]       in_digit,
    input  logic                   in_first,
    output logic [N*N*HEX_W-1:0]   grid_hex,
    output logic                   grid_valid,
    input  logic                   grid_ack,
    output logic                   err_digit,
    output logic                   err_frame,
    output logic [6:0]             cell_count
);
    import sudoku_pkg::*;

    localparam int NCELLS = N * N;
    localparam int GW     = NCELLS * HEX_W;

    loader_state_t    state, next_state;
    logic             accept, abort, ack, last_beat;
    logic [HEX_W-1:0] clean_digit;
    logic             illegal;

    sudoku_digit_check #(.W(HEX_W)) u_digit_check (
        .digit   (in_digit),
        .clean   (clean_digit),
        .illegal (illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        grid_valid = 1'b0;
        accept     = in_valid && in_ready;
        abort      = accept && in_first && (state == LOAD);
        ack        = grid_ack && (state == FULL);
        last_beat  = accept && !abort && (cell_count == 7'(NCELLS - 1));
        case (state)
            IDLE: if (accept) next_state = LOAD;
            LOAD: if (last_beat) next_state = FULL;
            FULL: begin
                grid_valid = 1'b1;
                if (ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Cell slot is addressed by cell_count, so an abort only has to clear and restart at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid_hex   <= '0;
            err_digit  <= 1'b0;
            err_frame  <= 1'b0;
            cell_count <= '0;
            in_ready   <= 1'b0;
        end else begin
            err_frame <= abort;
            in_ready  <= (next_state != FULL);
            if (ack) begin
                grid_hex   <= '0;
                err_digit  <= 1'b0;
                cell_count <= '0;
            end else if (abort) begin
                grid_hex   <= GW'(clean_digit);
                err_digit  <= illegal;
                cell_count <= 7'd1;
            end else if (accept) begin
                for (int i = 0; i < NCELLS; i++) begin
                    if (cell_count == 7'(i)) grid_hex[i*HEX_W +: HEX_W] <= clean_digit;
                end
                err_digit  <= err_digit | illegal;
                cell_count <= cell_count + 7'd1;
            end
        end
    end

endmodule
